// File: rtl/data_mem_dma_if.sv
// Bus bundle between the core/launch side, the copy sequencer and the data memory ports.
// The slave modport is the sequencer's view; the master modport is the surrounding system.
interface data_mem_dma_if #(
  parameter int W = 8,
  parameter int A = 8
);
  logic         CpuReq;
  logic         CpuWriteEn;
  logic [A-1:0] CpuAddress;
  logic [W-1:0] CpuDataIn;
  logic [W-1:0] CpuDataOut;
  logic         Start;
  logic [A-1:0] SrcAddr;
  logic [A-1:0] DstAddr;
  logic [A-1:0] Length;
  logic         Busy;
  logic         Done;
  logic         MemWriteEn;
  logic [A-1:0] MemAddress;
  logic [W-1:0] MemDataIn;
  logic [W-1:0] MemDataOut;

  modport slave (
    input  CpuReq, CpuWriteEn, CpuAddress, CpuDataIn,
    input  Start, SrcAddr, DstAddr, Length,
    input  MemDataOut,
    output CpuDataOut, Busy, Done,
    output MemWriteEn, MemAddress, MemDataIn
  );

  modport master (
    output CpuReq, CpuWriteEn, CpuAddress, CpuDataIn,
    output Start, SrcAddr, DstAddr, Length,
    output MemDataOut,
    input  CpuDataOut, Busy, Done,
    input  MemWriteEn, MemAddress, MemDataIn
  );
endinterface

// File: rtl/data_mem_dma.sv
// Block-copy sequencer and port arbiter for the single-port data memory.
// The core owns the memory whenever it requests it; the copy engine uses the idle cycles.
//
//   state | meaning
//   IDLE  | no copy running, memory port follows the core
//   RD    | read the byte at src into the buffer
//   WR    | write the buffer to dst, advance pointers, decrement count
module data_mem_dma #(
  parameter int W = 8,
  parameter int A = 8
) (
  input logic          Clk,
  input logic          Reset,
  data_mem_dma_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  state_t       state_q, state_d;
  logic [A-1:0] src_q, dst_q, count_q;
  logic [W-1:0] data_buf_q;
  logic         busy_q, done_q;
  logic         launch, zero_start, last_write, engine_go;
  logic         mem_we;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_din;

  assign engine_go = ~bus.CpuReq;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    launch     = 1'b0;
    zero_start = 1'b0;
    last_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (bus.Length != '0) begin
            launch  = 1'b1;
            state_d = RD;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      RD: if (engine_go) state_d = WR;
      WR: begin
        if (engine_go) begin
          if (count_q == A'(1)) begin
            last_write = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      src_q      <= '0;
      dst_q      <= '0;
      count_q    <= '0;
      data_buf_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= zero_start | last_write;
      if (launch) begin
        src_q   <= bus.SrcAddr;
        dst_q   <= bus.DstAddr;
        count_q <= bus.Length;
      end
      if (state_q == RD && engine_go) data_buf_q <= bus.MemDataOut;
      // Pointers wrap naturally at 2**A.
      if (state_q == WR && engine_go) begin
        src_q   <= src_q + A'(1);
        dst_q   <= dst_q + A'(1);
        count_q <= count_q - A'(1);
      end
    end
  end

  always_comb begin
    mem_addr = bus.CpuAddress;
    mem_din  = bus.CpuDataIn;
    mem_we   = bus.CpuReq & bus.CpuWriteEn;
    if (engine_go) begin
      case (state_q)
        RD: mem_addr = src_q;
        WR: begin
          mem_addr = dst_q;
          mem_din  = data_buf_q;
          mem_we   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.MemAddress = mem_addr;
  assign bus.MemDataIn  = mem_din;
  assign bus.MemWriteEn = mem_we & ~Reset;
  assign bus.CpuDataOut = bus.MemDataOut;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;

endmodule

// File: tb/tb_data_mem_dma.sv
// Bench for data_mem_dma: behavioural memory behind the DUT plus a reference byte-array model.
// Copies are predicted with a plain ascending loop; timing as 2 cycles/byte plus stalled cycles.
module tb_data_mem_dma;

  logic Clk = 1'b0;
  logic Reset;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int n_cmp = 0;
  int n_err = 0;

  data_mem_dma_if #(.W(8), .A(8)) bus ();
  data_mem_dma #(.W(8), .A(8)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  assign bus.MemDataOut = mem[bus.MemAddress];
  always @(posedge Clk) if (bus.MemWriteEn) mem[bus.MemAddress] <= bus.MemDataIn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  task automatic ref_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    logic [7:0] si, di;
    si = s;
    di = d;
    for (int i = 0; i < n; i++) begin
      ref_mem[di] = ref_mem[si];
      si = si + 8'd1;
      di = di + 8'd1;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] v);
    bus.CpuReq = 1'b1; bus.CpuWriteEn = 1'b1; bus.CpuAddress = a; bus.CpuDataIn = v;
    ref_mem[a] = v;
    tick();
    bus.CpuReq = 1'b0; bus.CpuWriteEn = 1'b0;
  endtask

  // mode 0: no core traffic; 1: random core traffic in 0xA0..0xBF; 2: core writes 0x55 to 0x80 on busy cycles 3,4
  task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                         input int mode, output int busy_cyc, output int stall_cyc, output int done_cnt);
    logic [7:0] a;
    busy_cyc = 0; stall_cyc = 0; done_cnt = 0;
    bus.Start = 1'b1; bus.SrcAddr = s; bus.DstAddr = d; bus.Length = l;
    tick();
    bus.Start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (bus.Done) done_cnt++;
      if (!bus.Busy) break;
      busy_cyc++;
      bus.CpuReq = 1'b0; bus.CpuWriteEn = 1'b0;
      if (mode == 2 && (busy_cyc == 3 || busy_cyc == 4)) begin
        bus.CpuReq = 1'b1; bus.CpuWriteEn = 1'b1; bus.CpuAddress = 8'h80; bus.CpuDataIn = 8'h55;
        ref_mem[8'h80] = 8'h55;
        stall_cyc++;
      end else if (mode == 1 && $urandom_range(99) < 30) begin
        a = 8'hA0 + 8'($urandom_range(31));
        bus.CpuReq = 1'b1; bus.CpuWriteEn = 1'($urandom_range(1)); bus.CpuAddress = a;
        bus.CpuDataIn = 8'($urandom);
        stall_cyc++;
        #1;
        if (bus.CpuWriteEn) ref_mem[a] = bus.CpuDataIn;
        else check("cpu_read", bus.CpuDataOut, ref_mem[a]);
      end
      tick();
      bus.CpuReq = 1'b0; bus.CpuWriteEn = 1'b0;
    end
    tick();
    check("done_width", bus.Done, 1'b0);
    ref_copy(s, d, int'(l));
  endtask

  initial begin
    int b, st, dn;
    logic [7:0] rs, rd, rl;
    bus.CpuReq = 0; bus.CpuWriteEn = 0; bus.CpuAddress = 0; bus.CpuDataIn = 0;
    bus.Start = 0; bus.SrcAddr = 0; bus.DstAddr = 0; bus.Length = 0;
    Reset = 1'b1;
    #12;
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_done", bus.Done, 1'b0);
    bus.CpuReq = 1'b1; bus.CpuWriteEn = 1'b1;
    #1;
    check("rst_we", bus.MemWriteEn, 1'b0);
    bus.CpuReq = 1'b0; bus.CpuWriteEn = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) cpu_write(8'(i), 8'($urandom));
    check("preload", mem_diffs(), 0);

    // basic copy
    cpu_write(8'h10, 8'hAA); cpu_write(8'h11, 8'hBB); cpu_write(8'h12, 8'hCC); cpu_write(8'h13, 8'hDD);
    do_copy(8'h10, 8'h40, 8'd4, 0, b, st, dn);
    check("basic_busy", b, 8);
    check("basic_done", dn, 1);
    check("basic_mem", mem_diffs(), 0);
    check("basic_b43", mem[8'h43], 8'hDD);

    // core contention
    do_copy(8'h10, 8'h48, 8'd4, 2, b, st, dn);
    check("cont_busy", b, 10);
    check("cont_done", dn, 1);
    check("cont_core", mem[8'h80], 8'h55);
    check("cont_mem", mem_diffs(), 0);

    // zero length
    do_copy(8'h10, 8'h60, 8'd0, 0, b, st, dn);
    check("zero_busy", b, 0);
    check("zero_done", dn, 1);
    check("zero_mem", mem_diffs(), 0);

    // wrap
    do_copy(8'hFE, 8'h20, 8'd3, 0, b, st, dn);
    check("wrap_busy", b, 6);
    check("wrap_mem", mem_diffs(), 0);
    check("wrap_b22", mem[8'h22], mem[8'h00]);

    // reset mid-copy after two bytes written
    bus.Start = 1'b1; bus.SrcAddr = 8'h30; bus.DstAddr = 8'h60; bus.Length = 8'd8;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    Reset = 1'b1;
    #1;
    check("abort_busy", bus.Busy, 1'b0);
    check("abort_done", bus.Done, 1'b0);
    check("abort_we", bus.MemWriteEn, 1'b0);
    tick();
    check("abort_we2", bus.MemWriteEn, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    check("abort_done2", bus.Done, 1'b0);
    ref_copy(8'h30, 8'h60, 2);
    check("abort_mem", mem_diffs(), 0);

    // start while busy is ignored
    bus.Start = 1'b1; bus.SrcAddr = 8'h50; bus.DstAddr = 8'h90; bus.Length = 8'd4;
    tick();
    bus.Start = 1'b0;
    b = 0; dn = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.Done) dn++;
      if (!bus.Busy) break;
      b++;
      if (b == 3) begin
        bus.Start = 1'b1; bus.SrcAddr = 8'h00; bus.DstAddr = 8'h95; bus.Length = 8'd2;
      end else bus.Start = 1'b0;
      tick();
    end
    bus.Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.Done) dn++;
    end
    check("busy2_busy", b, 8);
    check("busy2_done", dn, 1);
    ref_copy(8'h50, 8'h90, 4);
    check("busy2_mem", mem_diffs(), 0);

    // overlapping ascending copy
    cpu_write(8'h00, 8'h01); cpu_write(8'h01, 8'h02); cpu_write(8'h02, 8'h03); cpu_write(8'h03, 8'h04);
    do_copy(8'h00, 8'h01, 8'd3, 0, b, st, dn);
    check("ovl_mem", mem_diffs(), 0);
    check("ovl_b3", mem[8'h03], 8'h01);

    // random copies with random core traffic
    for (int k = 0; k < 16; k++) begin
      rs = 8'($urandom_range(8'h6F));
      rd = 8'($urandom_range(8'h6F));
      rl = 8'($urandom_range(16));
      do_copy(rs, rd, rl, 1, b, st, dn);
      check("rnd_busy", b, 2 * int'(rl) + st);
      check("rnd_done", dn, 1);
      check("rnd_mem", mem_diffs(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
